// File: rtl/led_breath_multi_pkg.sv
// Shared definitions for the multi-channel breathing-LED driver:
// mode encodings and the triangle duty helper.
package led_pkg;

  // Runtime display mode, sampled once per PWM frame.
  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ON     = 2'b01,
    MODE_BREATH = 2'b10,
    MODE_BLINK  = 2'b11
  } led_mode_t;

  // Fold a ramp position 0..2*steps-1 into a duty 0..steps-1:
  // rising on the first half, mirrored on the second half.
  function automatic int unsigned tri_duty(input int unsigned pos_i,
                                           input int unsigned steps);
    if (pos_i < steps) begin
      return pos_i;
    end
    return (2 * steps) - 1 - pos_i;
  endfunction

endpackage

// File: rtl/led_breath_multi_pwm_ch.sv
// One LED channel: applies the channel's fixed ramp offset to the global
// position, derives the lit condition for the current mode and registers
// the pin level.
module led_pwm_ch
  import led_pkg::*;
#(
  parameter int STEPS       = 1000,
  parameter int SW          = 10,
  parameter int PW          = 11,
  parameter int OFFSET      = 0,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] step,
  input  logic [PW-1:0] pos,
  input  led_mode_t     mode_q,
  output logic          led
);

  localparam logic UNLIT = ACTIVE_HIGH ? 1'b0 : 1'b1;

  logic [PW:0]   pos_sum;
  logic [PW-1:0] pos_ch;
  int unsigned   duty;
  logic          lit;
  logic          led_d;
  logic          led_q;

  // Channel ramp position and lit decision for the current counter state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    lit     = 1'b0;
    // Both operands are below 2*STEPS, so one conditional subtract at
    // PW+1 bits is enough to reduce the sum mod 2*STEPS.
    pos_sum = {1'b0, pos} + (PW+1)'(OFFSET);
    if (pos_sum >= (PW+1)'(2 * STEPS)) begin
      pos_sum = pos_sum - (PW+1)'(2 * STEPS);
    end
    pos_ch  = pos_sum[PW-1:0];
    duty    = tri_duty(int'(pos_ch), STEPS);
    unique case (mode_q)
      MODE_OFF:    lit = 1'b0;
      MODE_ON:     lit = 1'b1;
      MODE_BREATH: lit = (int'(step) < duty);
      MODE_BLINK:  lit = (pos_ch < PW'(STEPS));
      default:     lit = 1'b0;
    endcase
    led_d = ACTIVE_HIGH ? lit : ~lit;
  end

  // Registered pin drive; resets to the unlit level.
  // NOTE: reset is asynchronous active-low; state registers use
  // non-blocking assignments so all flops update from the same old values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q <= UNLIT;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_breath_multi.sv
// Multi-channel breathing-LED driver. Owns the tick/step/frame counters,
// the global ramp position, the frame-synchronous mode register and the
// frame_start pulse; each channel's PWM comparator lives in led_pwm_ch.
module led_breath_multi
  import led_pkg::*;
#(
  parameter int TICK_DIV    = 50,
  parameter int STEPS       = 1000,
  parameter int N_CH        = 8,
  parameter int STAGGER     = 125,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic            pause,
  output logic [N_CH-1:0] led,
  output logic            frame_start
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(STEPS);
  localparam int PW = $clog2(2 * STEPS);

  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] step_q, step_d;
  logic [PW-1:0] pos_q, pos_d;
  led_mode_t     mode_q, mode_d;
  logic          frame_start_q, frame_start_d;
  logic          tick_end;
  logic          frame_end;

  // Next-state for counters, ramp position and the frame-synchronous mode.
  always_comb begin
    tick_end      = (tick_q == TW'(TICK_DIV - 1));
    frame_end     = tick_end && (step_q == SW'(STEPS - 1));
    tick_d        = tick_end ? '0 : tick_q + 1'b1;
    step_d        = step_q;
    pos_d         = pos_q;
    mode_d        = mode_q;
    frame_start_d = frame_end;
    if (tick_end) begin
      step_d = (step_q == SW'(STEPS - 1)) ? '0 : step_q + 1'b1;
    end
    // Mode and ramp only move at frame boundaries so a frame never glitches.
    if (frame_end) begin
      mode_d = led_mode_t'(mode);
      if (!pause) begin
        pos_d = (pos_q == PW'(2 * STEPS - 1)) ? '0 : pos_q + 1'b1;
      end
    end
  end

  // Counter, ramp, mode and frame pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q        <= '0;
      step_q        <= '0;
      pos_q         <= '0;
      mode_q        <= MODE_OFF;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      step_q        <= step_d;
      pos_q         <= pos_d;
      mode_q        <= mode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

  // One PWM channel per LED, each with a fixed ramp offset.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam int OFFSET = (i * STAGGER) % (2 * STEPS);
    led_pwm_ch #(
      .STEPS       (STEPS),
      .SW          (SW),
      .PW          (PW),
      .OFFSET      (OFFSET),
      .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .step   (step_q),
      .pos    (pos_q),
      .mode_q (mode_q),
      .led    (led[i])
    );
  end

endmodule

// File: tb/tb_led_breath_multi.sv
// Directed bench for led_breath_multi with TICK_DIV=2, STEPS=4, N_CH=2,
// STAGGER=2 (frame = 8 cycles). A second instance with ACTIVE_HIGH=0
// shares all inputs. Frames are captured output-aligned: the 8 samples
// after a frame_start pulse, so bit k is the LED for counter state k.
module tb_led_breath_multi;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       pause;
  logic [1:0] led;
  logic [1:0] led_n;
  logic       frame_start;
  logic       frame_start_n;

  int pass_cnt  = 0;
  int check_cnt = 0;

  led_breath_multi #(
    .TICK_DIV(2), .STEPS(4), .N_CH(2), .STAGGER(2), .ACTIVE_HIGH(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .pause(pause),
    .led(led), .frame_start(frame_start)
  );

  led_breath_multi #(
    .TICK_DIV(2), .STEPS(4), .N_CH(2), .STAGGER(2), .ACTIVE_HIGH(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .mode(mode), .pause(pause),
    .led(led_n), .frame_start(frame_start_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Breath pattern for a duty: lit on the first 2*duty cycles of the frame.
  function automatic logic [7:0] breath_pat(input int d);
    case (d)
      0:       return 8'h00;
      1:       return 8'h03;
      2:       return 8'h0F;
      3:       return 8'h3F;
      default: return 8'hxx;
    endcase
  endfunction

  // Align to a frame_start pulse (bounded), then sample one output frame.
  // Optionally drive a new mode right after sample chg_at.
  task automatic capture(output logic [7:0] p0, output logic [7:0] p1,
                         output logic [7:0] fs, input int chg_at,
                         input logic [1:0] chg_mode);
    int n = 0;
    while (!frame_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("frame_sync", {31'd0, frame_start}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      p0[k] = led[0];
      p1[k] = led[1];
      fs[k] = frame_start;
      if (k == chg_at) mode = chg_mode;
    end
  endtask

  logic [7:0] p0, p1, fs;
  logic [1:0] acc;
  int         n;

  // Hand-derived per-frame duties for pos 2,3,4,5,6,7,0.
  int d0[7] = '{2, 3, 3, 2, 1, 0, 0};
  int d1[7] = '{3, 2, 1, 0, 0, 1, 2};
  // Blink lit flags for pos 2,3,4,5,6,7,0,1.
  bit b0[8] = '{1, 1, 0, 0, 0, 0, 1, 1};
  bit b1[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    rst = 1'b0; mode = 2'b00; pause = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_led", {30'd0, led}, 32'h0);
    check("rst_fs", {31'd0, frame_start}, 32'h0);
    check("rst_led_n", {30'd0, led_n}, 32'h3);

    // Scenario 1: BREATH requested at reset release; frame 1 stays dark.
    mode = 2'b10;
    rst  = 1'b1;
    acc  = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc |= led;
    end
    check("frame1_dark", {30'd0, acc}, 32'h0);
    check("frame1_fs_at_8", {31'd0, frame_start}, 32'h1);
    capture(p0, p1, fs, -1, 2'b00);
    check("f2_ch0", {24'd0, p0}, 32'h03);
    check("f2_ch1", {24'd0, p1}, 32'h3F);
    check("f2_fs", {24'd0, fs}, 32'h80);

    // Scenario 2: breath duty sequence for pos 2..7,0.
    for (int j = 0; j < 7; j++) begin
      capture(p0, p1, fs, -1, 2'b00);
      check($sformatf("breath_ch0_%0d", j), {24'd0, p0}, {24'd0, breath_pat(d0[j])});
      check($sformatf("breath_ch1_%0d", j), {24'd0, p1}, {24'd0, breath_pat(d1[j])});
      check($sformatf("breath_fs_%0d", j), {24'd0, fs}, 32'h80);
    end

    // Scenario 3: BLINK requested mid pos1 frame, active from pos2.
    mode = 2'b11;
    capture(p0, p1, fs, -1, 2'b00);
    check("pos1_still_breath_ch0", {24'd0, p0}, 32'h03);
    check("pos1_still_breath_ch1", {24'd0, p1}, 32'h3F);
    for (int j = 0; j < 8; j++) begin
      capture(p0, p1, fs, -1, 2'b00);
      check($sformatf("blink_ch0_%0d", j), {24'd0, p0}, b0[j] ? 32'hFF : 32'h00);
      check($sformatf("blink_ch1_%0d", j), {24'd0, p1}, b1[j] ? 32'hFF : 32'h00);
    end

    // Scenario 4: ON from pos3, OFF requested at cycle 3 of that frame.
    mode = 2'b01;
    capture(p0, p1, fs, -1, 2'b00);
    check("pos2_blink_ch0", {24'd0, p0}, 32'hFF);
    check("pos2_blink_ch1", {24'd0, p1}, 32'h00);
    capture(p0, p1, fs, 3, 2'b00);
    check("on_ch0", {24'd0, p0}, 32'hFF);
    check("on_ch1", {24'd0, p1}, 32'hFF);
    check("on_led_n", {30'd0, led_n}, 32'h0);
    capture(p0, p1, fs, -1, 2'b00);
    check("off_ch0", {24'd0, p0}, 32'h00);
    check("off_ch1", {24'd0, p1}, 32'h00);

    // Scenario 5: BREATH again, then pause while at pos2.
    mode = 2'b10;
    for (int j = 0; j < 5; j++) capture(p0, p1, fs, -1, 2'b00);
    check("pre_pause_pos1_ch0", {24'd0, p0}, 32'h03);
    pause = 1'b1;
    for (int j = 0; j < 3; j++) begin
      capture(p0, p1, fs, -1, 2'b00);
      check($sformatf("pause_ch0_%0d", j), {24'd0, p0}, 32'h0F);
      check($sformatf("pause_ch1_%0d", j), {24'd0, p1}, 32'h3F);
    end
    pause = 1'b0;
    capture(p0, p1, fs, -1, 2'b00);
    check("held_last_ch0", {24'd0, p0}, 32'h0F);
    capture(p0, p1, fs, -1, 2'b00);
    check("resume_ch0", {24'd0, p0}, 32'h3F);
    check("resume_ch1", {24'd0, p1}, 32'h0F);

    // Scenario 6: ON, then asynchronous reset mid-frame.
    mode = 2'b01;
    capture(p0, p1, fs, -1, 2'b00);
    check("pos4_breath_ch0", {24'd0, p0}, 32'h3F);
    check("pos4_breath_ch1", {24'd0, p1}, 32'h03);
    repeat (3) @(negedge clk);
    check("on_before_rst", {30'd0, led}, 32'h3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_led", {30'd0, led}, 32'h0);
    check("async_rst_fs", {31'd0, frame_start}, 32'h0);
    check("async_rst_led_n", {30'd0, led_n}, 32'h3);
    @(negedge clk);
    rst = 1'b1;
    n   = 0;
    acc = 2'b00;
    while (n < 20) begin
      @(negedge clk);
      n++;
      acc |= led;
      if (frame_start) break;
    end
    check("restart_frame_len", n, 32'd8);
    check("restart_frame_dark", {30'd0, acc}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
